// File: rtl/vme_pkg.sv
// Shared types and field positions for the VME A24 slave address decoder.
package vme_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_NOMATCH,
      S_DECODE,
      S_WAIT_DS,
      S_STROBE,
      S_ACK,
      S_BERR,
      S_RELEASE
   } vme_state_t;

   localparam logic [5:0] AM_A24_USER = 6'h39;
   localparam logic [5:0] AM_A24_SUP  = 6'h3D;

   localparam int BID_HI = 23;
   localparam int BID_LO = 19;
   localparam int DEV_HI = 15;
   localparam int DEV_LO = 12;
   localparam int CMD_HI = 11;
   localparam int CMD_LO = 2;

   function automatic logic am_ok(input logic [5:0] am);
      return (am == AM_A24_USER) || (am == AM_A24_SUP);
   endfunction

endpackage

// File: rtl/vme_sync.sv
// Two-flop synchroniser for asynchronous active-low bus strobes.
module vme_sync #(
   parameter int W = 1
) (
   input  logic         FASTCLK,
   input  logic         RST_B,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge FASTCLK or negedge RST_B) begin
      if (!RST_B) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/vme_addr_decode.sv
// VME A24 slave front end: strobe sync, slot match, device/command decode,
// DTACK watch and bus-error timeout.
module vme_addr_decode
   import vme_pkg::*;
#(
   parameter int NDEV    = 16,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic            FASTCLK,
   input  logic            RST_B,
   input  logic [4:0]      BOARD_ID,
   input  logic            VME_AS_B,
   input  logic [1:0]      VME_DS_B,
   input  logic            VME_WRITE_B,
   input  logic [5:0]      VME_AM,
   input  logic [23:1]     VME_ADDR,
   input  logic            DEV_DTACK_B,
   output logic            STROBE,
   output logic            WRITE_B,
   output logic [NDEV-1:0] DEVICE,
   output logic [9:0]      COMMAND,
   output logic            BERR_B,
   output logic            BUSY
);

   localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
   localparam logic [NDEV-1:0]  DEV_ONE = NDEV'(1);

   vme_state_t       state;
   logic             as_s;
   logic [1:0]       ds_s;
   logic             dtack_s;
   logic             ds_act;
   logic             hit;
   logic [3:0]       dev_idx;
   logic [CNT_W-1:0] cnt;
   logic             unused_addr;

   vme_sync #(.W(1)) u_sync_as (
      .FASTCLK (FASTCLK),
      .RST_B   (RST_B),
      .d       (VME_AS_B),
      .q       (as_s)
   );

   vme_sync #(.W(2)) u_sync_ds (
      .FASTCLK (FASTCLK),
      .RST_B   (RST_B),
      .d       (VME_DS_B),
      .q       (ds_s)
   );

   vme_sync #(.W(1)) u_sync_dtack (
      .FASTCLK (FASTCLK),
      .RST_B   (RST_B),
      .d       (DEV_DTACK_B),
      .q       (dtack_s)
   );

   assign ds_act      = ~&ds_s;
   assign hit         = am_ok(VME_AM) &&
                        (VME_ADDR[BID_HI:BID_LO] == BOARD_ID);
   assign unused_addr = ^{VME_ADDR[18:16], VME_ADDR[1]};
   assign BUSY        = (state != S_IDLE);

   always_ff @(posedge FASTCLK or negedge RST_B) begin
      if (!RST_B) begin
         state   <= S_IDLE;
         STROBE  <= 1'b0;
         WRITE_B <= 1'b1;
         DEVICE  <= '0;
         COMMAND <= '0;
         BERR_B  <= 1'b1;
         cnt     <= '0;
         dev_idx <= '0;
      end else if (state != S_IDLE && as_s) begin
         // AS released: abandon the cycle, keep latched address info
         state  <= S_IDLE;
         STROBE <= 1'b0;
         DEVICE <= '0;
         BERR_B <= 1'b1;
         cnt    <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (!as_s) begin
                  if (hit) begin
                     state   <= S_DECODE;
                     COMMAND <= VME_ADDR[CMD_HI:CMD_LO];
                     WRITE_B <= VME_WRITE_B;
                     dev_idx <= VME_ADDR[DEV_HI:DEV_LO];
                  end else begin
                     state <= S_NOMATCH;
                  end
               end
            end
            S_NOMATCH: begin
               state <= S_NOMATCH;
            end
            S_DECODE: begin
               DEVICE <= DEV_ONE << dev_idx;
               state  <= S_WAIT_DS;
            end
            S_WAIT_DS: begin
               if (ds_act) begin
                  STROBE <= 1'b1;
                  cnt    <= '0;
                  state  <= S_STROBE;
               end
            end
            S_STROBE: begin
               // DTACK has priority over a timeout on the same clock
               if (!dtack_s) begin
                  state <= S_ACK;
               end else if (cnt == TMO) begin
                  state  <= S_BERR;
                  STROBE <= 1'b0;
                  BERR_B <= 1'b0;
                  DEVICE <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_ACK: begin
               if (!ds_act) begin
                  state  <= S_RELEASE;
                  STROBE <= 1'b0;
                  DEVICE <= '0;
                  cnt    <= '0;
               end
            end
            S_BERR: begin
               if (!ds_act) begin
                  state  <= S_RELEASE;
                  BERR_B <= 1'b1;
                  DEVICE <= '0;
                  cnt    <= '0;
               end
            end
            S_RELEASE: begin
               STROBE <= 1'b0;
               BERR_B <= 1'b1;
               cnt    <= '0;
               // next data phase of a block transfer reuses the address
               if (ds_act) begin
                  DEVICE <= DEV_ONE << dev_idx;
                  state  <= S_WAIT_DS;
               end else begin
                  DEVICE <= '0;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vme_addr_decode.sv
// Directed bench for vme_addr_decode: vector table plus timeout, abort,
// block-transfer and async-reset sequences.
module tb_vme_addr_decode;

   logic        FASTCLK = 1'b0;
   logic        RST_B;
   logic [4:0]  BOARD_ID;
   logic        VME_AS_B;
   logic [1:0]  VME_DS_B;
   logic        VME_WRITE_B;
   logic [5:0]  VME_AM;
   logic [23:1] VME_ADDR;
   logic        DEV_DTACK_B;
   logic        STROBE;
   logic        WRITE_B;
   logic [15:0] DEVICE;
   logic [9:0]  COMMAND;
   logic        BERR_B;
   logic        BUSY;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [4:0]  bid;
      logic [5:0]  am;
      logic [23:0] addr;
      logic        wr_b;
      logic        hit;
      logic [15:0] dev;
      logic [9:0]  cmd;
   } vec_t;

   vec_t        vt [7];
   logic        exp_wr;
   logic [9:0]  exp_cmd;
   int          n;

   always #5 FASTCLK = ~FASTCLK;

   vme_addr_decode dut (
      .FASTCLK     (FASTCLK),
      .RST_B       (RST_B),
      .BOARD_ID    (BOARD_ID),
      .VME_AS_B    (VME_AS_B),
      .VME_DS_B    (VME_DS_B),
      .VME_WRITE_B (VME_WRITE_B),
      .VME_AM      (VME_AM),
      .VME_ADDR    (VME_ADDR),
      .DEV_DTACK_B (DEV_DTACK_B),
      .STROBE      (STROBE),
      .WRITE_B     (WRITE_B),
      .DEVICE      (DEVICE),
      .COMMAND     (COMMAND),
      .BERR_B      (BERR_B),
      .BUSY        (BUSY)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clks(input int k);
      repeat (k) @(negedge FASTCLK);
   endtask

   task automatic bus_idle();
      VME_AS_B    = 1'b1;
      VME_DS_B    = 2'b11;
      DEV_DTACK_B = 1'b1;
   endtask

   task automatic start(input vec_t v);
      BOARD_ID    = v.bid;
      VME_AM      = v.am;
      VME_ADDR    = v.addr[23:1];
      VME_WRITE_B = v.wr_b;
      VME_AS_B    = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " strobe"}, STROBE, 1'b0);
      chk({tag, " write_b"}, WRITE_B, 1'b1);
      chk({tag, " device"}, DEVICE, 16'h0);
      chk({tag, " command"}, COMMAND, 10'h0);
      chk({tag, " berr_b"}, BERR_B, 1'b1);
      chk({tag, " busy"}, BUSY, 1'b0);
   endtask

   initial begin
      vt[0] = '{5'd5,  6'h39, 24'h287004, 1'b1, 1'b1, 16'h0080, 10'h001};
      vt[1] = '{5'd6,  6'h39, 24'h287004, 1'b1, 1'b0, 16'h0000, 10'h000};
      vt[2] = '{5'd5,  6'h2D, 24'h287004, 1'b1, 1'b0, 16'h0000, 10'h000};
      vt[3] = '{5'd5,  6'h3D, 24'h28F3FC, 1'b0, 1'b1, 16'h8000, 10'h0FF};
      vt[4] = '{5'd31, 6'h39, 24'hF80008, 1'b1, 1'b1, 16'h0001, 10'h002};
      vt[5] = '{5'd0,  6'h3D, 24'h003FFC, 1'b0, 1'b1, 16'h0008, 10'h3FF};
      vt[6] = '{5'd0,  6'h3E, 24'h003FFC, 1'b1, 1'b0, 16'h0000, 10'h000};

      RST_B       = 1'b0;
      BOARD_ID    = 5'd0;
      VME_AM      = 6'h0;
      VME_ADDR    = '0;
      VME_WRITE_B = 1'b1;
      bus_idle();
      clks(3);
      chk_reset_vals("reset");
      RST_B = 1'b1;
      clks(2);
      chk_reset_vals("post-reset idle");
      exp_wr  = 1'b1;
      exp_cmd = 10'h0;

      for (int i = 0; i < 7; i++) begin
         start(vt[i]);
         clks(5);
         if (vt[i].hit) begin
            exp_wr  = vt[i].wr_b;
            exp_cmd = vt[i].cmd;
         end
         chk($sformatf("v%0d busy", i), BUSY, 1'b1);
         chk($sformatf("v%0d device", i), DEVICE, vt[i].dev);
         chk($sformatf("v%0d command", i), COMMAND, exp_cmd);
         chk($sformatf("v%0d write_b", i), WRITE_B, exp_wr);
         VME_DS_B = 2'b00;
         clks(4);
         chk($sformatf("v%0d strobe", i), STROBE, vt[i].hit);
         if (vt[i].hit) DEV_DTACK_B = 1'b0;
         clks(4);
         chk($sformatf("v%0d strobe held", i), STROBE, vt[i].hit);
         chk($sformatf("v%0d berr_b", i), BERR_B, 1'b1);
         VME_DS_B = 2'b11;
         clks(4);
         chk($sformatf("v%0d strobe off", i), STROBE, 1'b0);
         chk($sformatf("v%0d device off", i), DEVICE, 16'h0);
         chk($sformatf("v%0d busy release", i), BUSY, 1'b1);
         bus_idle();
         clks(4);
         chk($sformatf("v%0d idle", i), BUSY, 1'b0);
         chk($sformatf("v%0d cmd hold", i), COMMAND, exp_cmd);
         chk($sformatf("v%0d wr hold", i), WRITE_B, exp_wr);
      end

      // bus-error timeout with no DTACK
      start(vt[0]);
      clks(5);
      VME_DS_B = 2'b00;
      for (int k = 0; k < 20 && !STROBE; k++) clks(1);
      chk("to strobe rise", STROBE, 1'b1);
      n = 0;
      while (BERR_B && n < 400) begin
         clks(1);
         n++;
      end
      chk("to berr delay", n, 256);
      chk("to strobe low", STROBE, 1'b0);
      chk("to busy", BUSY, 1'b1);
      clks(3);
      chk("to berr hold", BERR_B, 1'b0);
      VME_DS_B = 2'b11;
      clks(4);
      chk("to berr release", BERR_B, 1'b1);
      chk("to busy release", BUSY, 1'b1);
      bus_idle();
      clks(4);
      chk("to idle", BUSY, 1'b0);

      // AS dropped while waiting for DS
      start(vt[3]);
      clks(5);
      chk("abort device set", DEVICE, 16'h8000);
      VME_AS_B = 1'b1;
      clks(3);
      chk("abort busy", BUSY, 1'b0);
      chk("abort device", DEVICE, 16'h0);
      VME_DS_B = 2'b00;
      clks(4);
      chk("abort no strobe", STROBE, 1'b0);
      chk("abort cmd hold", COMMAND, 10'h0FF);
      bus_idle();
      clks(4);

      // block transfer: second data phase under the same AS
      start(vt[4]);
      clks(5);
      VME_DS_B = 2'b10;
      clks(4);
      DEV_DTACK_B = 1'b0;
      clks(4);
      VME_DS_B    = 2'b11;
      DEV_DTACK_B = 1'b1;
      clks(4);
      chk("blk release device", DEVICE, 16'h0);
      chk("blk release strobe", STROBE, 1'b0);
      VME_DS_B = 2'b01;
      clks(5);
      chk("blk second strobe", STROBE, 1'b1);
      chk("blk second device", DEVICE, 16'h0001);
      bus_idle();
      clks(4);
      chk("blk idle", BUSY, 1'b0);

      // asynchronous reset in the middle of a data phase
      start(vt[0]);
      clks(5);
      VME_DS_B = 2'b00;
      clks(5);
      chk("rst pre strobe", STROBE, 1'b1);
      #2 RST_B = 1'b0;
      #1;
      chk_reset_vals("async rst");
      bus_idle();
      @(negedge FASTCLK);
      RST_B = 1'b1;
      clks(3);
      chk("rst stays idle", BUSY, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
